arb_rr4: RTL and testbench
==========================

# arb_rr4

Four-requester round-robin arbiter with grant hold and timeout. It sits directly upstream of the 4-to-2 encoder and drives it with a strictly one-hot (or all-zero) grant vector, which the encoder turns into a 2-bit index. Arbitration is fair: the most recently served requester has lowest priority on the next arbitration.

## Interface
- MAX_HOLD, default 8: maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CW, default 4: width of the hold counter; must satisfy 2^CW > MAX_HOLD.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset, synchronous and active-high.
- req  input  4  request lines; bit i high means requester i wants the resource.
- done  input  1  release pulse from the current grantee; ignored when no grant is active.
- gnt  output  4  registered grant vector; one-hot or 4'b0000, never more than one bit set.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse marking a forced release.

## Operation
- States: IDLE (gnt = 0) and GRANT (one bit of gnt set).
- Rotating pointer ptr[1:0] holds the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE with req != 0: the first set bit in search order wins. Next cycle: gnt = one-hot(winner), state GRANT, ptr = winner+1 mod 4, counter = 0.
- IDLE with req == 0: stay in IDLE; ptr unchanged.
- GRANT: counter increments by 1 each cycle, saturating at 2^CW-1.
- Release conditions, evaluated in GRANT. Any one of them returns the block to IDLE next cycle with gnt = 0 and counter = 0:
  - done = 1;
  - req[granted] = 0 (requester withdrew);
  - MAX_HOLD != 0 and counter == MAX_HOLD-1. In this case only, timeout = 1 in the same cycle gnt clears.
- If more than one release condition is true in the same cycle, a single release occurs. timeout pulses only if the counter condition is among them.
- Requests from other requesters do not disturb an active grant.
- There is no back-to-back grant: every release is followed by at least one IDLE cycle with gnt = 0.

## Timing
- Reset (rst high at a clock edge): gnt = 4'b0000, gnt_valid = 0, timeout = 0, ptr = 0, counter = 0, state IDLE. rst has priority over every other input.
- Reset asserted during GRANT drops the grant at the next edge. It does not pulse timeout.
- Grant latency: req sampled at edge N in IDLE gives gnt valid after edge N+1.
- Release latency: a release condition sampled at edge M gives gnt = 0 after M+1. The earliest next grant is after M+2.
- Maximum hold: with MAX_HOLD = K, gnt stays high for exactly K cycles when done never arrives and req stays high.
- Pointer wrap: a winner of 3 sets ptr = 0.
- All outputs are registered; none depends combinationally on req or done.

## Test plan
- Reset: assert rst for 2 cycles with req = 4'b1111 -> gnt = 0, gnt_valid = 0, timeout = 0 throughout. After release, first grant is gnt = 4'b0001.
- Round-robin: hold req = 4'b1111 and pulse done one cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Fairness/wrap: after a grant to requester 2, set req = 4'b0101 -> next grant is 0001 (search starts at 3, wraps to 0), not 0100.
- Withdrawal: grant 0010, then drop req[1] with done = 0 -> gnt = 0 on the next cycle, timeout = 0.
- Timeout: MAX_HOLD = 8, req = 4'b1000, done held 0 -> gnt = 1000 for exactly 8 cycles, then gnt = 0 with a one-cycle timeout pulse, then re-grant of 1000 two cycles after the release edge.
- Simultaneous events: done = 1 on the same cycle the counter hits MAX_HOLD-1 -> single release with timeout = 1. Also, rst mid-grant -> gnt = 0 with timeout = 0, and ptr returns to 0.

Source files
------------

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter with grant hold, done/withdraw release and
// an optional hold timeout. Grant is registered and always one-hot or zero.
module arb_rr4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam bit          TO_EN     = (MAX_HOLD != 0);
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr, ptr_nxt, win;
  logic          found;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    gnt_nxt;
  logic          timeout_nxt;
  logic          hold_hit_c, release_c;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // First requester at or after ptr, wrapping modulo 4
  always_comb begin
    logic [1:0] idx;
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign hold_hit_c = TO_EN && (cnt == HOLD_LAST);
  assign release_c  = done || ((gnt & req) == 4'b0000) || hold_hit_c;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   if (release_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    gnt_nxt     = gnt;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (found) begin
          gnt_nxt = 4'b0001 << win;
          ptr_nxt = win + 2'd1;
        end else begin
          gnt_nxt = 4'b0000;
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_nxt     = 4'b0000;
          cnt_nxt     = '0;
          timeout_nxt = hold_hit_c;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        gnt_nxt = 4'b0000;
        cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_rr4.sv
// Directed self-checking bench for arb_rr4 with MAX_HOLD = 8.
module tb_arb_rr4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  arb_rr4 #(.MAX_HOLD(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are observed 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset cyc%0d: gnt=%b v=%b to=%b, want 0000 0 0", c, gnt, gnt_valid, timeout);
      end
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL first_grant: gnt=%b v=%b, want 0001 1", gnt, gnt_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      done = 1'b1;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_idle%0d: gnt=%b v=%b to=%b, want 0000 0 0", k, gnt, gnt_valid, timeout);
      end
      done = 1'b0;
      step();
      n_cmp++;
      if (gnt !== exp_seq[k] || gnt_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_grant%0d: gnt=%b v=%b, want %b 1", k, gnt, gnt_valid, exp_seq[k]);
      end
    end
  endtask

  task automatic test_fairness_wrap();
    done = 1'b1;
    step();
    done = 1'b0; req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_bad++;
      $display("FAIL wrap_setup: gnt=%b, want 0100", gnt);
    end
    done = 1'b1; req = 4'b0101;
    step();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL wrap_release: gnt=%b, want 0000", gnt);
    end
    done = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL wrap_grant: gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_withdrawal();
    done = 1'b1;
    step();
    done = 1'b0; req = 4'b0010;
    step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL wd_grant: gnt=%b, want 0010", gnt);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_release: gnt=%b v=%b to=%b, want 0000 0 0", gnt, gnt_valid, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_idle: gnt=%b v=%b, want 0000 0", gnt, gnt_valid);
    end
  endtask

  task automatic test_timeout();
    req = 4'b1000; done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b1000 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL to_hold%0d: gnt=%b to=%b, want 1000 0", c, gnt, timeout);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL to_release: gnt=%b to=%b, want 0000 1", gnt, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL to_regrant: gnt=%b to=%b, want 1000 0", gnt, timeout);
    end
  endtask

  task automatic test_simultaneous();
    // Grant to 3 active with counter 0; others request without disturbing it
    req = 4'b1011;
    for (int c = 0; c < 7; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b1000) begin
        n_bad++;
        $display("FAIL sim_hold%0d: gnt=%b, want 1000", c, gnt);
      end
    end
    req = 4'b1000; done = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL sim_done_to: gnt=%b to=%b, want 0000 1", gnt, timeout);
    end
    done = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b1000 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL sim_regrant: gnt=%b to=%b, want 1000 0", gnt, timeout);
    end
    done = 1'b1;
    step();
    done = 1'b0; req = 4'b0010;
    step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL sim_pre_rst: gnt=%b, want 0010", gnt);
    end
    rst = 1'b1; req = 4'b0110;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sim_rst: gnt=%b v=%b to=%b, want 0000 0 0", gnt, gnt_valid, timeout);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL sim_ptr_reset: gnt=%b, want 0010", gnt);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    test_reset();
    test_round_robin();
    test_fairness_wrap();
    test_withdrawal();
    test_timeout();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
